// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK byte-to-I/Q splitter controller.
package qpsk_pkg;

  // Controller states; PRE is only reachable when the preamble option is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    EMIT  = 3'd3,
    PRE   = 3'd4
  } state_t;

  localparam int         BYTE_W       = 8;
  localparam int         NIB_W        = 4;
  localparam logic [7:0] PREAMBLE_DEF = 8'hA5;

endpackage

// File: rtl/qpsk_frame_cnt.sv
// Frame byte counter: counts data groups and wraps from FRAME_LEN-1 back to 0.
// is_first_o is high while the counter sits at 0, i.e. the next data group
// opens a new frame.
module qpsk_frame_cnt #(
  parameter int FRAME_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  output logic is_first_o
);
  import qpsk_pkg::*;

  // A one-entry frame still needs a 1-bit register; it simply never leaves 0.
  localparam int            CW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: advance on enable, wrapping at the last index of the frame.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_first_o = (cnt_q == '0);

endmodule

// File: rtl/qpsk_split_ctrl.sv
// Sequencer for the byte-to-I/Q bit splitter (PISO + toggle + even/odd SIPO).
// Accepts one byte, pulses the splitter load strobe, waits out the
// serialisation window, captures the even (I) and odd (Q) nibbles and offers
// them downstream as one symbol group with a start-of-frame flag.
// Optional build macro: QPSK_CTRL_PREAMBLE_EN inserts a PREAMBLE sync group at
// the start of every frame; that group carries sym_sop and the data groups do not.
module qpsk_split_ctrl #(
  parameter int BYTE_W    = qpsk_pkg::BYTE_W,
  parameter int SHIFT_CYC = 8,
  parameter int FRAME_LEN = 16
`ifdef QPSK_CTRL_PREAMBLE_EN
  ,
  parameter logic [BYTE_W-1:0] PREAMBLE = BYTE_W'(qpsk_pkg::PREAMBLE_DEF)
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BYTE_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [BYTE_W-1:0]          spl_data,
  output logic                       spl_ld,
  input  logic [qpsk_pkg::NIB_W-1:0] spl_even,
  input  logic [qpsk_pkg::NIB_W-1:0] spl_odd,
  output logic [qpsk_pkg::NIB_W-1:0] sym_i,
  output logic [qpsk_pkg::NIB_W-1:0] sym_q,
  output logic                       sym_sop,
  output logic                       sym_valid,
  input  logic                       sym_ready,
  output logic                       busy
);
  import qpsk_pkg::*;

  localparam int            SW         = (SHIFT_CYC > 1) ? $clog2(SHIFT_CYC) : 1;
  localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFT_CYC - 1);

  state_t              state_q, state_d;
  logic [SW-1:0]       shift_q, shift_d;
  logic [BYTE_W-1:0]   spl_data_q, spl_data_d;
  logic [NIB_W-1:0]    nib_i_q, nib_i_d;
  logic [NIB_W-1:0]    nib_q_q, nib_q_d;
  logic                sop_q, sop_d;
  logic                frame_inc;
  logic                frame_first;
`ifdef QPSK_CTRL_PREAMBLE_EN
  logic                pre_sent_q, pre_sent_d;
  logic                is_pre_q, is_pre_d;
  logic                need_pre;

  assign need_pre = frame_first & ~pre_sent_q;
`endif

  qpsk_frame_cnt #(
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (frame_inc),
    .is_first_o (frame_first)
  );

  // Next-state, handshake and strobe decode; every register holds by default.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    spl_data_d = spl_data_q;
    nib_i_d    = nib_i_q;
    nib_q_d    = nib_q_q;
    sop_d      = sop_q;
    frame_inc  = 1'b0;
    in_ready   = 1'b0;
    spl_ld     = 1'b0;
    sym_valid  = 1'b0;
    busy       = 1'b1;
`ifdef QPSK_CTRL_PREAMBLE_EN
    pre_sent_d = pre_sent_q;
    is_pre_d   = is_pre_q;
`endif

    case (state_q)
      IDLE: begin
        busy = 1'b0;
`ifdef QPSK_CTRL_PREAMBLE_EN
        // The preamble goes out only once a real byte is waiting, so an idle
        // link never emits orphan sync groups. The byte stays pending
        // (in_ready low) until the preamble group has been handed off.
        if (need_pre) begin
          if (in_valid) begin
            state_d = PRE;
          end
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            spl_data_d = in_data;
            state_d    = LOAD;
          end
        end
`else
        in_ready = 1'b1;
        if (in_valid) begin
          spl_data_d = in_data;
          state_d    = LOAD;
        end
`endif
      end

`ifdef QPSK_CTRL_PREAMBLE_EN
      PRE: begin
        spl_data_d = PREAMBLE;
        is_pre_d   = 1'b1;
        state_d    = LOAD;
      end
`endif

      LOAD: begin
        spl_ld  = 1'b1;
        shift_d = '0;
        state_d = SHIFT;
      end

      SHIFT: begin
        shift_d = shift_q + SW'(1);
        if (shift_q == SHIFT_LAST) begin
          nib_i_d = spl_even;
          nib_q_d = spl_odd;
`ifdef QPSK_CTRL_PREAMBLE_EN
          sop_d   = is_pre_q;
`else
          sop_d   = frame_first;
`endif
          state_d = EMIT;
        end
      end

      EMIT: begin
        sym_valid = 1'b1;
        if (sym_ready) begin
          state_d = IDLE;
`ifdef QPSK_CTRL_PREAMBLE_EN
          if (is_pre_q) begin
            is_pre_d   = 1'b0;
            pre_sent_d = 1'b1;
          end else begin
            frame_inc  = 1'b1;
            // The flag only matters while the frame count is 0, so clearing it
            // on every data group is the same as clearing it on the wrap.
            pre_sent_d = 1'b0;
          end
`else
          frame_inc = 1'b1;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shift counter, splitter data and captured symbol registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      spl_data_q <= '0;
      nib_i_q    <= '0;
      nib_q_q    <= '0;
      sop_q      <= 1'b0;
`ifdef QPSK_CTRL_PREAMBLE_EN
      pre_sent_q <= 1'b0;
      is_pre_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      spl_data_q <= spl_data_d;
      nib_i_q    <= nib_i_d;
      nib_q_q    <= nib_q_d;
      sop_q      <= sop_d;
`ifdef QPSK_CTRL_PREAMBLE_EN
      pre_sent_q <= pre_sent_d;
      is_pre_q   <= is_pre_d;
`endif
    end
  end

  assign spl_data = spl_data_q;
  assign sym_i    = nib_i_q;
  assign sym_q    = nib_q_q;
  assign sym_sop  = sop_q;

endmodule
